// File: rtl/driver_pkg.sv
// Shared definitions for the driver read scheduler: FSM state type,
// timeout/error constants and the round-robin search helper.
package driver_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

    localparam int          SCHED_TIMEOUT_DEF = 1024;
    localparam logic [31:0] SCHED_ERR_DATA    = 32'h0;
    localparam int          RR_MAX            = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit at or above ptr, wrapping at n-1 by explicit compare so
    // non-power-of-two requester counts never alias onto unused slots.
    function automatic rr_pick_t next_rr(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
        rr_pick_t   r;
        logic [2:0] c;
        r = '0;
        c = ptr;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n && !r.found && req[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
            c = (c == 3'(n - 1)) ? 3'd0 : c + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/driver_rr_arb.sv
// Combinational round-robin pick over the eligible requesters.
module driver_rr_arb
    import driver_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_found
);

    rr_pick_t pick;

    always_comb begin
        pick      = next_rr(RR_MAX'(eligible), 3'(rr_ptr), NUM_REQ);
        gnt_idx   = PTR_W'(pick.idx);
        gnt_found = pick.found;
    end

endmodule

// File: rtl/driver_rd_sched.sv
// Round-robin sharing of the driver_dp master read port, one read in flight.
// Optional WAIT timeout with error completion under DRIVER_SCHED_TIMEOUT_EN.
module driver_rd_sched
    import driver_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sched_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        rsp_val,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         master_addr,
    output logic                      master_rd,
    input  logic [DATA_W-1:0]         master_data_in,
    input  logic                      master_data_in_val,
    output logic                      busy,
    output logic                      stray_data
);

    localparam int                PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    sched_state_t        state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  served_q, served_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                stray_q, stray_d;
    logic [NUM_REQ-1:0]  eligible, gnt_oh;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_found;
    logic                tmo_hit;

    assign eligible = req & ~served_q;
    assign gnt_oh   = NUM_REQ'(1) << gnt_q;

    driver_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .gnt_idx   (arb_idx),
        .gnt_found (arb_found)
    );

`ifdef DRIVER_SCHED_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign tmo_hit = (cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
            err_d = !master_data_in_val && tmo_hit;
        end
    end

    assign rsp_err = (state_q == RESP) && err_q;
`else
    logic tmo_unused;
    assign tmo_unused = ^TMO_LAST;
    assign tmo_hit    = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            served_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            served_q <= served_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            stray_q  <= stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sched_en && arb_found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (master_data_in_val || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        served_d = served_q;
        addr_d   = addr_q;
        data_d   = data_q;
        // Any return outside WAIT has no owner; remember it until reset.
        stray_d  = stray_q || (master_data_in_val && state_q != WAIT);
        case (state_q)
            IDLE: begin
                served_d = '0;
                if (sched_en && arb_found) begin
                    gnt_d  = arb_idx;
                    addr_d = req_addr[arb_idx*ADDR_W +: ADDR_W];
                end
            end
            WAIT: begin
                if (master_data_in_val) data_d = master_data_in;
                else if (tmo_hit)       data_d = DATA_W'(SCHED_ERR_DATA);
            end
            RESP: begin
                rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                served_d = gnt_oh;
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_val     = (state_q == RESP) ? gnt_oh : '0;
        rsp_data    = (state_q == RESP) ? data_q : '0;
        master_rd   = (state_q == ISSUE);
        master_addr = addr_q;
        busy        = (state_q != IDLE);
        stray_data  = stray_q;
    end

endmodule
